// File: rtl/frame_seq_pkg.sv
// rtl/frame_seq_pkg.sv - shared states, constants and LFSR helper for the frame sequencer
package frame_seq_pkg;

    localparam int         FRAME_W   = 9;
    localparam logic [1:0] LEVEL_MAX = 2'd3;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] LFSR_SEED = 8'h01;

    typedef enum logic [1:0] {
        FADE_IN  = 2'd0,
        HOLD     = 2'd1,
        FADE_OUT = 2'd2,
        NEXT     = 2'd3
    } seq_state_t;

    // Fibonacci step for x^8+x^6+x^5+x^4+1: shift left, feed back the tap parity
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// rtl/frame_sequencer_if.sv - control inputs and frame outputs of the frame sequencer
interface frame_sequencer_if;
    import frame_seq_pkg::*;

    logic               vsync;
    logic               pause;
    logic               step;
    logic [1:0]         speed;
    logic               frame_tick;
    logic [FRAME_W-1:0] frame_no;
    logic [1:0]         scene;
    logic [1:0]         level;

    modport master (
        input  vsync, pause, step, speed,
        output frame_tick, frame_no, scene, level
    );

    modport slave (
        output vsync, pause, step, speed,
        input  frame_tick, frame_no, scene, level
    );

endinterface

// File: rtl/frame_edge_det.sv
// rtl/frame_edge_det.sv - vsync edge pulse plus single-step request tracking
module frame_edge_det #(
    parameter bit VSYNC_ACT_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync,
    input  logic pause,
    input  logic step,
    output logic frame_tick,
    output logic adv,
    output logic step_adv
);

    logic vs_act;
    logic vs_q;
    logic tick;
    logic step_q;
    logic step_pend;
    logic step_edge;
    logic pend_eff;

    assign vs_act    = vsync ^ VSYNC_ACT_LOW;
    assign tick      = vs_act & ~vs_q;
    assign step_edge = step & ~step_q;
    // a step edge landing on the tick cycle is consumed by that same tick
    assign pend_eff  = step_pend | (step_edge & pause);
    assign adv       = tick & (~pause | pend_eff);
    assign step_adv  = tick & pend_eff;

    // vsync history keeps sampling through reset so a level held across reset is not a new edge
    always_ff @(posedge clk) begin
        vs_q <= vs_act;
    end

    // registered frame pulse and the pending single-step request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_tick <= 1'b0;
            step_q     <= 1'b0;
            step_pend  <= 1'b0;
        end else begin
            frame_tick <= tick;
            step_q     <= step;
            if (adv) begin
                step_pend <= 1'b0;
            end else if (step_edge & pause) begin
                step_pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - frame counter and scene fade FSM; FRAME_SEQ_RANDOM_EN selects random scene order
module frame_sequencer
    import frame_seq_pkg::*;
#(
    parameter int HOLD_FRAMES   = 240,
    parameter int FADE_FRAMES   = 8,
    parameter int N_SCENES      = 4,
    parameter bit VSYNC_ACT_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    frame_sequencer_if.master bus
);

    localparam logic [7:0] FADE_LAST = 8'(FADE_FRAMES - 1);
    localparam logic [9:0] HOLD_LAST = 10'(HOLD_FRAMES - 1);
    localparam logic [2:0] SCENE_CNT = 3'(N_SCENES);

    seq_state_t         state, state_n;
    logic [7:0]         fade_cnt, fade_cnt_n;
    logic [9:0]         hold_cnt, hold_cnt_n;
    logic [1:0]         level, level_n;
    logic [1:0]         scene, scene_n;
    logic [1:0]         scene_pick;
    logic [FRAME_W-1:0] frame_no, frame_no_n;
    logic               adv;
    logic               step_adv;

    frame_edge_det #(
        .VSYNC_ACT_LOW (VSYNC_ACT_LOW)
    ) u_edge (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync      (bus.vsync),
        .pause      (bus.pause),
        .step       (bus.step),
        .frame_tick (bus.frame_tick),
        .adv        (adv),
        .step_adv   (step_adv)
    );

`ifdef FRAME_SEQ_RANDOM_EN
    logic [7:0] lfsr;
    logic [1:0] cand;

    // free-running scene randomiser
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    // random candidate in range, bumped by one when it would repeat the current scene
    always_comb begin
        cand       = 2'(32'(lfsr[1:0]) % N_SCENES);
        scene_pick = cand;
        if (cand == scene) begin
            scene_pick = (({1'b0, cand} + 3'd1) == SCENE_CNT) ? 2'd0 : cand + 2'd1;
        end
    end
`else
    // round-robin through the scene list
    always_comb begin
        scene_pick = (({1'b0, scene} + 3'd1) == SCENE_CNT) ? 2'd0 : scene + 2'd1;
    end
`endif

    // next frame number, fade counters, level and scene
    always_comb begin
        state_n    = state;
        fade_cnt_n = fade_cnt;
        hold_cnt_n = hold_cnt;
        level_n    = level;
        scene_n    = scene;
        frame_no_n = frame_no;
        if (adv) begin
            frame_no_n = frame_no + (step_adv ? 9'd1 : ({7'd0, bus.speed} + 9'd1));
        end
        unique case (state)
            FADE_IN: begin
                if (adv) begin
                    if (fade_cnt == FADE_LAST) begin
                        fade_cnt_n = '0;
                        level_n    = level + 2'd1;
                        if (level_n == LEVEL_MAX) state_n = HOLD;
                    end else begin
                        fade_cnt_n = fade_cnt + 8'd1;
                    end
                end
            end
            HOLD: begin
                if (adv) begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt_n = '0;
                        state_n    = FADE_OUT;
                    end else begin
                        hold_cnt_n = hold_cnt + 10'd1;
                    end
                end
            end
            FADE_OUT: begin
                if (adv) begin
                    if (fade_cnt == FADE_LAST) begin
                        fade_cnt_n = '0;
                        level_n    = level - 2'd1;
                        if (level_n == 2'd0) state_n = NEXT;
                    end else begin
                        fade_cnt_n = fade_cnt + 8'd1;
                    end
                end
            end
            NEXT: begin
                scene_n = scene_pick;
                state_n = FADE_IN;
            end
            default: state_n = FADE_IN;
        endcase
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= FADE_IN;
            fade_cnt <= '0;
            hold_cnt <= '0;
            level    <= '0;
            scene    <= '0;
            frame_no <= '0;
        end else begin
            state    <= state_n;
            fade_cnt <= fade_cnt_n;
            hold_cnt <= hold_cnt_n;
            level    <= level_n;
            scene    <= scene_n;
            frame_no <= frame_no_n;
        end
    end

    assign bus.frame_no = frame_no;
    assign bus.scene    = scene;
    assign bus.level    = level;

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - scoreboard bench for frame_sequencer
module tb_frame_sequencer;

    localparam int HOLD = 4;
    localparam int FADE = 2;
    localparam int NSC  = 4;
    localparam int CYC  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    frame_sequencer_if bus ();

    frame_sequencer #(
        .HOLD_FRAMES   (HOLD),
        .FADE_FRAMES   (FADE),
        .N_SCENES      (NSC),
        .VSYNC_ACT_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int fn;
        int sc;
        int lv;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   k     = 0;
    int   fn    = 0;
    bit   pend  = 1'b0;

    task automatic check(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    function automatic int m_q(input int n);
        return ((n - 1) % CYC) + 1;
    endfunction

    function automatic int m_level(input int n);
        int q;
        if (n == 0) return 0;
        q = m_q(n);
        if (q <= 6) return q / 2;
        if (q <= 10) return 3;
        return (17 - q) / 2;
    endfunction

    function automatic int m_scene(input int n);
        if (n == 0) return 0;
        return ((n - 1) / CYC) % NSC;
    endfunction

    task automatic expect_tick();
        exp_t e;
        if (!bus.pause || pend) begin
            k++;
            fn   = (fn + (pend ? 1 : int'(bus.speed) + 1)) % 512;
            pend = 1'b0;
        end
        e.fn = fn;
        e.sc = m_scene(k);
        e.lv = m_level(k);
        sb.push_back(e);
    endtask

    task automatic vs_pulse(input bit chk, input int next_scene);
        expect_tick();
        @(posedge clk); #1 bus.vsync = 1'b0;
        @(negedge clk); if (chk) check("tick_before_edge", int'(bus.frame_tick), 0);
        @(negedge clk); if (chk) check("tick_one_clk_after", int'(bus.frame_tick), 1);
        @(negedge clk); if (chk) check("tick_width", int'(bus.frame_tick), 0);
        if (next_scene >= 0) check("scene_after_next", int'(bus.scene), next_scene);
        @(posedge clk); #1 bus.vsync = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic step_edge();
        @(posedge clk); #1 bus.step = 1'b1;
        @(posedge clk); #1 bus.step = 1'b0;
        if (bus.pause) pend = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.frame_tick) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_tick: frame_tick=1 with nothing expected, frame_no=%0d", bus.frame_no);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_frame_no", int'(bus.frame_no), e.fn);
                check("sb_level", int'(bus.level), e.lv);
`ifndef FRAME_SEQ_RANDOM_EN
                check("sb_scene", int'(bus.scene), e.sc);
`endif
            end
        end
    end

    initial begin : stim
        int prev;
        bus.vsync = 1'b1;
        bus.pause = 1'b0;
        bus.step  = 1'b0;
        bus.speed = 2'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_frame_no", int'(bus.frame_no), 0);
        check("reset_scene", int'(bus.scene), 0);
        check("reset_level", int'(bus.level), 0);
        check("reset_frame_tick", int'(bus.frame_tick), 0);

        repeat (3) vs_pulse(1'b1, -1);
        check("frame_no_after_3", int'(bus.frame_no), 3);

        while (k < 15) vs_pulse(1'b0, -1);
        vs_pulse(1'b0, 1);
        while (k < 63) vs_pulse(1'b0, -1);
        vs_pulse(1'b0, 0);

        while (fn < 510) vs_pulse(1'b0, -1);
        #1 bus.speed = 2'd3;
        vs_pulse(1'b0, -1);
        check("frame_no_wrap", int'(bus.frame_no), 2);

        while (m_level(k) != 2) vs_pulse(1'b0, -1);
        #1 bus.pause = 1'b1;
        repeat (10) vs_pulse(1'b0, -1);
        check("paused_frame_no", int'(bus.frame_no), 22);
        check("paused_level", int'(bus.level), 2);
        step_edge();
        repeat (4) vs_pulse(1'b0, -1);
        check("step_frame_no", int'(bus.frame_no), 23);
        check("step_level", int'(bus.level), 2);

        #1 bus.pause = 1'b0;
        while (m_q(k) != 12) vs_pulse(1'b0, -1);
        expect_tick();
        @(posedge clk); #1 bus.vsync = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_frame_no", int'(bus.frame_no), 0);
        check("midrst_scene", int'(bus.scene), 0);
        check("midrst_level", int'(bus.level), 0);
        check("midrst_frame_tick", int'(bus.frame_tick), 0);
        repeat (4) @(posedge clk);
        #1 bus.vsync = 1'b1;
        repeat (4) @(posedge clk);
        k    = 0;
        fn   = 0;
        pend = 1'b0;
        vs_pulse(1'b1, -1);
        vs_pulse(1'b0, -1);
        check("post_reset_frame_no", int'(bus.frame_no), 8);

`ifdef FRAME_SEQ_RANDOM_EN
        prev = int'(bus.scene);
        for (int n = 0; n < 20; n++) begin
            do vs_pulse(1'b0, -1); while (m_q(k) != CYC);
            check("rand_scene_changed", int'(int'(bus.scene) != prev), 1);
            check("rand_scene_range", int'(int'(bus.scene) < NSC), 1);
            prev = int'(bus.scene);
        end
`else
        prev = 0;
`endif

        repeat (4) @(posedge clk);
        check("scoreboard_drained", sb.size(), prev * 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
